// File: rtl/mdu_pkg.sv
// mdu_pkg: shared op codes, FSM states and op-class helpers for the multiply/divide unit
package mdu_pkg;

   typedef enum logic [3:0] {
      OP_NOP   = 4'd0,
      OP_MULT  = 4'd1,
      OP_MULTU = 4'd2,
      OP_DIV   = 4'd3,
      OP_DIVU  = 4'd4,
      OP_MADD  = 4'd5,
      OP_MADDU = 4'd6,
      OP_MSUB  = 4'd7,
      OP_MSUBU = 4'd8,
      OP_MTHI  = 4'd9,
      OP_MTLO  = 4'd10
   } mdu_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2,
      ST_FIX  = 2'd3
   } mdu_state_e;

   function automatic logic is_signed(mdu_op_e op);
      return op inside {OP_MULT, OP_DIV, OP_MADD, OP_MSUB};
   endfunction

   function automatic logic is_mul(mdu_op_e op);
      return op inside {OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU};
   endfunction

   function automatic logic is_div(mdu_op_e op);
      return op inside {OP_DIV, OP_DIVU};
   endfunction

endpackage

// File: rtl/mdu_div_seq.sv
// mdu_div_seq: unsigned restoring divider core, one quotient bit per step
module mdu_div_seq #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic             step,
   input  logic [WIDTH-1:0] dvd,
   input  logic [WIDTH-1:0] dvs,
   output logic [WIDTH-1:0] quot,
   output logic [WIDTH-1:0] rem
);

   logic [WIDTH-1:0] quot_q, quot_d, rem_q, rem_d, dvs_q, dvs_d;
   logic [WIDTH:0]   part, diff;

   // Shift the next dividend bit into the partial remainder and keep the subtraction only if it does not borrow
   always_comb begin
      part   = {rem_q, quot_q[WIDTH-1]};
      diff   = part - {1'b0, dvs_q};
      quot_d = load ? dvd : step ? {quot_q[WIDTH-2:0], ~diff[WIDTH]} : quot_q;
      rem_d  = load ? '0 : step ? (diff[WIDTH] ? part[WIDTH-1:0] : diff[WIDTH-1:0]) : rem_q;
      dvs_d  = load ? dvs : dvs_q;
   end

   // Divider state registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         quot_q <= '0;
         rem_q  <= '0;
         dvs_q  <= '0;
      end else begin
         quot_q <= quot_d;
         rem_q  <= rem_d;
         dvs_q  <= dvs_d;
      end
   end

   assign quot = quot_q;
   assign rem  = rem_q;

endmodule

// File: rtl/mdu_iter.sv
// mdu_iter: HI/LO owning multiply/divide unit with fixed-latency multiply and iterative divide
module mdu_iter
   import mdu_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int MUL_LAT = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   input  logic             flush,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = $clog2(WIDTH);

   mdu_state_e           state_q, state_d;
   mdu_op_e              opc, op_q, op_d;
   logic [WIDTH-1:0]     a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d;
   logic [WIDTH-1:0]     abs_a, abs_b, quot, rem, div_q, div_r;
   logic [2*WIDTH-1:0]   ea, eb, mp, acc, prod_q, prod_d;
   logic [MUL_LAT-1:0]   vld_q, vld_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic                 done_q, done_d;
   logic                 accept, mul_acc, div_load, div_step, mul_commit, fix_commit, a_neg, q_neg;

   assign opc    = mdu_op_e'(op);
   assign busy   = state_q != ST_IDLE;
   assign accept = start && !busy && !flush;

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   // Next state: flush always returns to idle; divide runs WIDTH steps then one sign-fix cycle
   always_comb begin
      state_d = state_q;
      if (flush) state_d = ST_IDLE;
      else
         case (state_q)
            ST_IDLE: state_d = !accept ? ST_IDLE : is_mul(opc) ? ST_MUL : is_div(opc) ? ST_DIV : ST_IDLE;
            ST_MUL:  state_d = vld_q[MUL_LAT-1] ? ST_IDLE : ST_MUL;
            ST_DIV:  state_d = (cnt_q == CW'(WIDTH-1)) ? ST_FIX : ST_DIV;
            ST_FIX:  state_d = ST_IDLE;
         endcase
   end

   // FSM outputs: divider control and commit strobes
   always_comb begin
      mul_acc    = accept && is_mul(opc);
      div_load   = accept && is_div(opc);
      div_step   = state_q == ST_DIV && !flush;
      mul_commit = state_q == ST_MUL && vld_q[MUL_LAT-1] && !flush;
      fix_commit = state_q == ST_FIX && !flush;
   end

   mdu_div_seq #(.WIDTH(WIDTH)) u_div (
      .clk   (clk),
      .reset (reset),
      .load  (div_load),
      .step  (div_step),
      .dvd   (abs_a),
      .dvs   (abs_b),
      .quot  (quot),
      .rem   (rem)
   );

   // Datapath: product formed at accept from live operands and {hi,lo}; divide signs applied in FIX
   always_comb begin
      ea       = is_signed(opc) ? {{WIDTH{src_a[WIDTH-1]}}, src_a} : {{WIDTH{1'b0}}, src_a};
      eb       = is_signed(opc) ? {{WIDTH{src_b[WIDTH-1]}}, src_b} : {{WIDTH{1'b0}}, src_b};
      mp       = ea * eb;
      acc      = {hi_q, lo_q};
      abs_a    = (is_signed(opc) && src_a[WIDTH-1]) ? -src_a : src_a;
      abs_b    = (is_signed(opc) && src_b[WIDTH-1]) ? -src_b : src_b;
      a_neg    = is_signed(op_q) && a_q[WIDTH-1];
      q_neg    = is_signed(op_q) && (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
      div_q    = (b_q == '0) ? '1 : q_neg ? -quot : quot;
      div_r    = (b_q == '0) ? a_q : a_neg ? -rem : rem;
      prod_d   = !mul_acc ? prod_q : (opc inside {OP_MADD, OP_MADDU}) ? acc + mp :
                 (opc inside {OP_MSUB, OP_MSUBU}) ? acc - mp : mp;
      vld_d    = vld_q << 1;
      vld_d[0] = mul_acc;
      vld_d    = flush ? '0 : vld_d;
      cnt_d    = (flush || div_load) ? '0 : div_step ? cnt_q + 1'b1 : cnt_q;
      op_d     = accept ? opc : op_q;
      a_d      = accept ? src_a : a_q;
      b_d      = accept ? src_b : b_q;
      hi_d     = (accept && opc == OP_MTHI) ? src_a : mul_commit ? prod_q[2*WIDTH-1:WIDTH] : fix_commit ? div_r : hi_q;
      lo_d     = (accept && opc == OP_MTLO) ? src_a : mul_commit ? prod_q[WIDTH-1:0] : fix_commit ? div_q : lo_q;
      done_d   = mul_commit || fix_commit;
   end

   // Datapath registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         op_q   <= OP_NOP;
         a_q    <= '0;
         b_q    <= '0;
         prod_q <= '0;
         vld_q  <= '0;
         cnt_q  <= '0;
         hi_q   <= '0;
         lo_q   <= '0;
         done_q <= 1'b0;
      end else begin
         op_q   <= op_d;
         a_q    <= a_d;
         b_q    <= b_d;
         prod_q <= prod_d;
         vld_q  <= vld_d;
         cnt_q  <= cnt_d;
         hi_q   <= hi_d;
         lo_q   <= lo_d;
         done_q <= done_d;
      end
   end

   assign hi   = hi_q;
   assign lo   = lo_q;
   assign done = done_q;

endmodule

// File: tb/tb_mdu_iter.sv
// tb_mdu_iter: directed-vector self-checking bench for mdu_iter (WIDTH=32, MUL_LAT=5)
module tb_mdu_iter;
   import mdu_pkg::*;

   localparam int W = 32;
   localparam int L = 5;

   logic         clk = 1'b0;
   logic         reset, start, flush;
   logic [3:0]   op;
   logic [W-1:0] src_a, src_b, hi, lo, h0, l0;
   logic         busy, done, seen;
   int           n_cmp = 0;
   int           n_bad = 0;

   mdu_iter #(.WIDTH(W), .MUL_LAT(L)) dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .op    (op),
      .src_a (src_a),
      .src_b (src_b),
      .flush (flush),
      .busy  (busy),
      .done  (done),
      .hi    (hi),
      .lo    (lo)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
      start = 1'b1; op = o; src_a = a; src_b = b;
      tick(1);
      start = 1'b0; op = OP_NOP;
   endtask

   task automatic mul_run(input string tag, input logic [3:0] o, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [63:0] exp);
      issue(o, a, b);
      chk({tag, "/busy_T"}, busy, 1);
      tick(L - 1);
      chk({tag, "/busy_pre"}, busy, 1);
      tick(1);
      chk({tag, "/busy_commit"}, busy, 0);
      chk({tag, "/done"}, done, 1);
      chk({tag, "/hilo"}, {hi, lo}, exp);
      tick(1);
      chk({tag, "/done_drop"}, done, 0);
   endtask

   task automatic div_run(input string tag, input logic [3:0] o, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] eh, input logic [W-1:0] el,
                          input logic intrude);
      logic [W-1:0] hb;
      hb = hi;
      issue(o, a, b);
      if (intrude) begin
         start = 1'b1; op = OP_MTHI; src_a = 32'h0000DEAD;
         tick(1);
         start = 1'b0; op = OP_NOP;
         chk({tag, "/start_ignored"}, hi, hb);
         tick(W - 1);
      end else tick(W);
      chk({tag, "/busy_pre"}, busy, 1);
      tick(1);
      chk({tag, "/busy_commit"}, busy, 0);
      chk({tag, "/done"}, done, 1);
      chk({tag, "/hi"}, hi, eh);
      chk({tag, "/lo"}, lo, el);
      tick(1);
      chk({tag, "/done_drop"}, done, 0);
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; flush = 1'b0; op = OP_NOP; src_a = '0; src_b = '0;
      tick(2);
      chk("rst/hi", hi, 0);
      chk("rst/lo", lo, 0);
      chk("rst/busy", busy, 0);
      chk("rst/done", done, 0);
      reset = 1'b0;
      tick(1);

      mul_run("mult", OP_MULT, 32'hFFFFFFFE, 32'd3, 64'hFFFFFFFF_FFFFFFFA);
      mul_run("multu", OP_MULTU, 32'hFFFFFFFF, 32'd2, 64'h00000001_FFFFFFFE);

      issue(OP_MTHI, 32'h0, 32'h0);
      issue(OP_MTLO, 32'hFFFFFFFF, 32'h0);
      chk("mtlo/busy", busy, 0);
      chk("mtlo/done", done, 0);
      mul_run("maddu", OP_MADDU, 32'd1, 32'd1, 64'h00000001_00000000);
      issue(OP_MTHI, 32'h0, 32'h0);
      issue(OP_MTLO, 32'hFFFFFFFF, 32'h0);
      mul_run("msub", OP_MSUB, 32'd1, 32'd1, 64'h00000000_FFFFFFFE);

      div_run("div_neg", OP_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
      div_run("div_mix", OP_DIV, 32'd100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFF2, 1'b0);
      div_run("divu", OP_DIVU, 32'hFFFFFFFF, 32'h10, 32'hF, 32'h0FFFFFFF, 1'b0);
      div_run("divu_z", OP_DIVU, 32'd7, 32'd0, 32'd7, 32'hFFFFFFFF, 1'b0);
      div_run("div_z", OP_DIV, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b0);
      div_run("div_ovf", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 1'b1);

      h0 = hi; l0 = lo;
      issue(OP_DIVU, 32'd100, 32'd3);
      tick(9);
      flush = 1'b1;
      tick(1);
      flush = 1'b0;
      chk("flush/busy", busy, 0);
      seen = 1'b0;
      repeat (40) begin
         tick(1);
         if (done) seen = 1'b1;
      end
      chk("flush/no_done", seen, 0);
      chk("flush/hi", hi, h0);
      chk("flush/lo", lo, l0);

      start = 1'b1; flush = 1'b1; op = OP_MTLO; src_a = 32'h55;
      tick(1);
      chk("flush_start/mtlo", lo, l0);
      op = OP_MULT; src_a = 32'd3; src_b = 32'd3;
      tick(1);
      start = 1'b0; flush = 1'b0; op = OP_NOP;
      chk("flush_start/busy", busy, 0);

      issue(4'hF, 32'h1, 32'h1);
      chk("undef/busy", busy, 0);
      chk("undef/hi", hi, h0);
      issue(OP_NOP, 32'h1, 32'h1);
      chk("nop/busy", busy, 0);

      issue(OP_MTHI, 32'hAAAA, 32'h0);
      chk("mthi/hi", hi, 32'hAAAA);
      issue(OP_DIV, 32'd1000, 32'd7);
      tick(5);
      #2 reset = 1'b1;
      #1;
      chk("arst/hi", hi, 0);
      chk("arst/lo", lo, 0);
      chk("arst/busy", busy, 0);
      @(posedge clk);
      #1 reset = 1'b0;
      issue(OP_MTHI, 32'h1234, 32'h0);
      chk("mthi2/hi", hi, 32'h1234);
      chk("mthi2/busy", busy, 0);
      chk("mthi2/done", done, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
